// File: rtl/block_assembler.sv
// Packs a stream of DATA_W-bit words into BLOCK_WORDS-wide blocks, with
// flush of partial blocks (zero-padded) and a single-entry held output.
module block_assembler #(
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 64,
  parameter int MSB_FIRST   = 1,
  localparam int CNT_W      = $clog2(BLOCK_WORDS + 1),
  localparam int BLK_W      = DATA_W * BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BLK_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [BLK_W-1:0]   data_q, data_d;
  int unsigned        slot;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cnt_inc = cnt_q + CNT_W'(1);
    slot    = (MSB_FIRST != 0) ? (32'(BLOCK_WORDS) - 32'd1 - 32'(cnt_q))
                               : 32'(cnt_q);
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            data_d[slot*DATA_W +: DATA_W] = in_data;
            cnt_d = cnt_inc;
          end
          // cnt_d already includes a word taken alongside flush; the register
          // holds zeros in unfilled slots, so no explicit padding is needed
          if (in_valid && (cnt_inc == CNT_W'(BLOCK_WORDS)))
            state_d = HOLD;
          else if (flush && (cnt_d != '0))
            state_d = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            state_d = FILL;
            cnt_d   = '0;
            data_d  = '0;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
          data_d  = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_block_assembler.sv
// Directed bench for block_assembler: two instances (MSB-first and LSB-first)
// share one stimulus stream and are checked against hand-computed blocks.
module tb_block_assembler;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear, flush, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        m_in_ready, m_out_valid, l_in_ready, l_out_valid;
  logic [31:0] m_out_data, l_out_data;
  logic [2:0]  m_out_count, l_out_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_assembler #(.DATA_W(8), .BLOCK_WORDS(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .n_rst(n_rst), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(m_in_ready),
    .out_valid(m_out_valid), .out_data(m_out_data), .out_ready(out_ready),
    .out_count(m_out_count));

  block_assembler #(.DATA_W(8), .BLOCK_WORDS(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(l_in_ready),
    .out_valid(l_out_valid), .out_data(l_out_data), .out_ready(out_ready),
    .out_count(l_out_count));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    in_valid = 1'b1;
    in_data = a; tick();
    in_data = b; tick();
    in_data = c; tick();
    in_data = d; tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
  endtask

  logic [7:0]  w, w0;
  logic [31:0] exp_m, exp_l;
  int          idle, nblk;
  logic        rdy_now;

  initial begin
    n_rst = 1'b0; clear = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_valid",  {m_out_valid, l_out_valid}, 2'b00);
    check("rst_ready",  {m_in_ready,  l_in_ready},  2'b11);
    check("rst_data",   {m_out_data,  l_out_data},  64'h0);
    check("rst_count",  {m_out_count, l_out_count}, 6'h0);
    n_rst = 1'b1;
    tick();

    // full block, both packing orders, then hold stability
    feed4(8'h11, 8'h22, 8'h33, 8'h44);
    check("full_valid", {m_out_valid, l_out_valid}, 2'b11);
    check("full_ready", {m_in_ready,  l_in_ready},  2'b00);
    check("full_msb",   m_out_data, 32'h11223344);
    check("full_lsb",   l_out_data, 32'h44332211);
    check("full_count", {m_out_count, l_out_count}, {3'd4, 3'd4});
    in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_lsb", l_out_data, 32'h44332211);
      check("hold_cnt", l_out_count, 3'd4);
      check("hold_vld", l_out_valid, 1'b1);
    end
    in_valid = 1'b0; flush = 1'b0;
    drain();
    check("drain_ready", {m_in_ready, l_in_ready},  2'b11);
    check("drain_valid", {m_out_valid, l_out_valid}, 2'b00);
    check("drain_data",  {m_out_data, l_out_data},  64'h0);

    // partial block flush
    in_valid = 1'b1;
    in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    check("flush_valid", {m_out_valid, l_out_valid}, 2'b11);
    check("flush_msb",   m_out_data, 32'hAABB0000);
    check("flush_lsb",   l_out_data, 32'h0000BBAA);
    check("flush_count", {m_out_count, l_out_count}, {3'd2, 3'd2});
    drain();

    // flush on an empty block is ignored
    flush = 1'b1; tick();
    flush = 1'b0;
    check("flush_empty", {m_out_valid, l_out_valid}, 2'b00);
    tick();
    check("flush_empty2", {m_out_valid, l_out_valid}, 2'b00);

    // flush together with the first word emits a one-word block
    in_valid = 1'b1; in_data = 8'h5A; flush = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush1_valid", {m_out_valid, l_out_valid}, 2'b11);
    check("flush1_msb",   m_out_data, 32'h5A000000);
    check("flush1_lsb",   l_out_data, 32'h0000005A);
    check("flush1_count", {m_out_count, l_out_count}, {3'd1, 3'd1});
    drain();

    // clear drops partial data and the word presented with it
    in_valid = 1'b1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'h03; clear = 1'b1; tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_valid", {m_out_valid, l_out_valid}, 2'b00);
    check("clr_data",  {m_out_data, l_out_data},  64'h0);
    check("clr_count", {m_out_count, l_out_count}, 6'h0);
    feed4(8'h04, 8'h05, 8'h06, 8'h07);
    check("clr_blk_msb", m_out_data, 32'h04050607);
    check("clr_blk_lsb", l_out_data, 32'h07060504);
    check("clr_blk_cnt", m_out_count, 3'd4);
    drain();

    // continuous streaming with the consumer always ready
    out_ready = 1'b1; in_valid = 1'b1;
    w = 8'h10; w0 = 8'h10; idle = 0; nblk = 0;
    for (int i = 0; i < 15; i++) begin
      rdy_now = m_in_ready;
      if (!rdy_now) idle++;
      if (m_out_valid) begin
        exp_m = {w0, w0 + 8'd1, w0 + 8'd2, w0 + 8'd3};
        exp_l = {w0 + 8'd3, w0 + 8'd2, w0 + 8'd1, w0};
        check("stream_msb", m_out_data, exp_m);
        check("stream_lsb", l_out_data, exp_l);
        w0 = w0 + 8'd4;
        nblk++;
      end
      in_data = w;
      tick();
      if (rdy_now) w = w + 8'd1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_blocks", nblk, 3);
    check("stream_idle",   idle, 3);
    check("stream_state",  {m_in_ready, m_out_valid}, 2'b10);

    // asynchronous reset while holding a block
    feed4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    check("pre_rst_valid", m_out_valid, 1'b1);
    n_rst = 1'b0;
    #2;
    check("arst_valid", {m_out_valid, l_out_valid}, 2'b00);
    check("arst_data",  {m_out_data, l_out_data},  64'h0);
    check("arst_ready", {m_in_ready, l_in_ready},  2'b11);
    n_rst = 1'b1;
    tick();
    feed4(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    check("post_rst_msb", m_out_data, 32'hB1B2B3B4);
    check("post_rst_lsb", l_out_data, 32'hB4B3B2B1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_assembler.md
BLOCK_ASSEMBLER -- requirements
Module: block_assembler

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of one input word in bits.
REQ-002 Parameter BLOCK_WORDS, default 64, SHALL set the number of words per output block; legal range is 2..256.
REQ-003 Parameter MSB_FIRST, default 1, SHALL select packing order: 1 places the first word in the most-significant slot, 0 places it in the least-significant slot.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous discard of partial or held block.
REQ-007 flush  input  1  request to emit the current partial block, zero-padded.
REQ-008 in_valid  input  1  in_data holds a word.
REQ-009 in_data  input  DATA_W  input word.
REQ-010 in_ready  output  1  block accepts a word this cycle.
REQ-011 out_valid  output  1  out_data holds a complete or flushed block.
REQ-012 out_data  output  DATA_W*BLOCK_WORDS  assembled block.
REQ-013 out_ready  input  1  consumer accepts the block this cycle.
REQ-014 out_count  output  $clog2(BLOCK_WORDS+1)  number of valid words in out_data; BLOCK_WORDS for a full block.

Function
REQ-015 The block SHALL have two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A word SHALL be accepted when in_valid and in_ready are both 1 on a rising edge; no other condition accepts a word.
REQ-017 Slot k is bits [DATA_W*(k+1)-1 : DATA_W*k]. With MSB_FIRST=1 the n-th accepted word (n from 0) SHALL occupy slot BLOCK_WORDS-1-n; with MSB_FIRST=0 it SHALL occupy slot n.
REQ-018 In FILL, an internal word counter SHALL increment by 1 per accepted word; the counter plus one accepted word reaching BLOCK_WORDS SHALL move the state to HOLD on that edge, with out_count=BLOCK_WORDS.
REQ-019 In FILL, flush=1 with counter>=1 SHALL move the state to HOLD, set out_count to the counter value (including a word accepted that same cycle), and set unfilled slots to zero.
REQ-020 flush=1 with counter=0 and no word accepted SHALL be ignored; flush in HOLD SHALL be ignored.
REQ-021 In HOLD, out_data and out_count SHALL stay stable until out_ready=1; on that edge the state SHALL return to FILL with counter=0 and the assembly register zeroed.
REQ-022 in_ready SHALL be 0 in HOLD, so input is back-pressured; the first word of the next block SHALL be accepted no earlier than the cycle after the handshake.
REQ-023 Latency: out_valid SHALL assert in the cycle immediately after the edge that accepts the last word, or the edge that samples flush.
REQ-024 clear=1 SHALL take priority over flush, in_valid and out_ready: on that edge the state becomes FILL, the counter becomes 0 and the data is zeroed; a word presented with clear is dropped.
REQ-025 in_ready and out_valid SHALL be driven from registered state only, with no combinational path from in_valid, flush or out_ready.

Reset
REQ-026 While n_rst=0, the block SHALL be in FILL with counter=0, out_data=0, out_count=0, out_valid=0 and in_ready=1.
REQ-027 Reset asserted mid-block or in HOLD SHALL discard all held data without emitting it.

Verification (DATA_W=8, BLOCK_WORDS=4)
REQ-028 MSB_FIRST=1; feed 0x11,0x22,0x33,0x44 on consecutive cycles -> next cycle out_valid=1, out_data=0x11223344, out_count=4, in_ready=0.
REQ-029 MSB_FIRST=0; same words -> out_data=0x44332211; hold out_ready=0 for 5 cycles -> out_data is unchanged; pulse out_ready -> next cycle in_ready=1, out_valid=0.
REQ-030 MSB_FIRST=1; feed 0xAA,0xBB, then flush -> out_data=0xAABB0000, out_count=2; flush with counter=0 -> out_valid stays 0.
REQ-031 Feed 0x01,0x02, then assert clear together with in_valid carrying 0x03 -> counter=0 and 0x03 is dropped; the next 4 words form a clean block.
REQ-032 Hold in_valid=1 continuously with out_ready=1 -> exactly one idle input cycle per block; blocks contain only consecutive words, with no loss and no duplication.
REQ-033 Assert n_rst=0 in HOLD -> out_valid=0 and out_data=0 immediately (asynchronously); after release, the first block built contains only post-reset words.
